instr_mem: RTL

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_mem.sv
// Single-cycle-latency instruction memory with a ready/valid fetch port,
// a one-entry response register, flush support and a program-load write port.
module instr_mem #(
  parameter int                 ADDR_W   = 6,
  parameter int                 DATA_W   = 32,
  parameter int                 PC_W     = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [PC_W-1:0]   rsp_pc,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Power-up contents are NOPs; reset never touches the array.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic [PC_W-1:0]   rsp_pc_q,    rsp_pc_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic [ADDR_W-1:0] word_idx;
  logic [DATA_W-1:0] rd_word;

  assign word_idx     = req_pc[ADDR_W+1:2];
  assign misaligned   = |req_pc[1:0];
  // Shift form stays legal when PC_W == ADDR_W+2 (no upper bits to test).
  assign out_of_range = (req_pc >> (ADDR_W + 2)) != '0;
  assign rd_word      = mem_q[word_idx];

  assign req_ready = !rst && (!rsp_valid_q || rsp_ready || flush);
  assign accept    = req_valid && req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_err_d   = misaligned || out_of_range;
      rsp_instr_d = (misaligned || out_of_range) ? NOP_WORD : rd_word;
    end else if (rsp_ready || flush) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_pc_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Read-first: the fetch path samples mem_q before this edge's write lands.
  always_ff @(posedge clk) begin
    if (prog_we && !rst) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_err   = rsp_err_q;

endmodule
